dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 5 +
 rtl/dmem_arbiter_starve_counter.sv | 18 +
 rtl/dmem_arbiter.sv | 57 +++++
 tb/tb_dmem_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: arbiter state encoding and default starvation limit
package Defs;
    typedef enum logic {ARB, HOST_ACK} ArbState;
    localparam int STARVE_LIMIT_DEFAULT = 4;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// starve_counter: saturating count of cycles the host lost to the CPU
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic atLimit
);
    localparam int W = LIMIT < 1 ? 1 : $clog2(LIMIT + 1);
    logic [W-1:0] count;
    assign atLimit = count >= W'(LIMIT);
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && !atLimit) count <= count + 1'b1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between CPU MEM stage and a host port
module dmem_arbiter
    import Defs::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_stall,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    ArbState state, stateNext;
    logic hostEligible, atLimit, cpuGrant, hostGrant;
    starve_counter #(.LIMIT(STARVE_LIMIT)) starveCnt (
        .clk(clk),
        .reset(reset),
        .inc(hostEligible && host_req && cpuGrant),
        .clr(hostGrant || !host_req),
        .atLimit(atLimit)
    );
    always_comb begin
        hostEligible = state == ARB;
        cpuGrant     = cpu_req && !(hostEligible && host_req && atLimit);
        hostGrant    = !cpuGrant && host_req && hostEligible;
        stateNext    = (state == ARB && hostGrant) ? HOST_ACK : ARB;
        mem_we       = cpuGrant ? cpu_we : hostGrant && host_we;
        mem_re       = cpuGrant ? !cpu_we : hostGrant && !host_we;
        mem_addr     = cpuGrant ? cpu_addr : hostGrant ? host_addr : 8'h00;
        mem_wdata    = cpuGrant ? cpu_wdata : hostGrant ? host_wdata : 8'h00;
        cpu_rdata    = cpuGrant ? mem_rdata : 8'h00;
        cpu_stall    = cpu_req && hostGrant;
        host_ack     = state == HOST_ACK;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= ARB;
            host_rdata <= 8'h00;
        end else begin
            state <= stateNext;
            if (hostGrant && !host_we) host_rdata <= mem_rdata;
        end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scoreboard bench for dmem_arbiter with STARVE_LIMIT=4
module tb_dmem_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
    logic [7:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
    logic cpu_stall, host_ack, mem_we, mem_re;
    logic [7:0] mem [256];
    typedef struct {string tag; logic [7:0] v;} Exp;
    Exp expQ[$];
    int nAssert = 0, nFail = 0;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk)
        if (reset && !host_ack) begin
            mem[8'h10] <= 8'h5A;
            mem[8'h07] <= 8'hC4;
        end else if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic expect_val(input string tag, input logic [7:0] v);
        expQ.push_back('{tag, v});
    endtask

    task automatic check(input logic [7:0] obs);
        Exp e;
        nAssert++;
        if (expQ.size() == 0) begin
            nFail++;
            $error("FAIL scoreboard-empty observed=%h expected=none", obs);
        end else begin
            e = expQ.pop_front();
            assert (obs === e.v) else begin
                nFail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic step(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
        @(negedge clk);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        #1;
    endtask

    initial begin
        @(negedge clk);
        #1;
        expect_val("rst_host_ack", 8'h0);  check({7'b0, host_ack});
        expect_val("rst_host_rdata", 8'h0); check(host_rdata);
        expect_val("rst_mem_we", 8'h0);    check({7'b0, mem_we});
        expect_val("rst_mem_re", 8'h0);    check({7'b0, mem_re});
        expect_val("rst_mem_addr", 8'h0);  check(mem_addr);
        reset = 1'b0;
        // CPU-only load
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("cpu_load_rdata", 8'h5A); check(cpu_rdata);
        expect_val("cpu_load_stall", 8'h0);  check({7'b0, cpu_stall});
        expect_val("cpu_load_re", 8'h1);     check({7'b0, mem_re});
        expect_val("cpu_load_addr", 8'h10);  check(mem_addr);
        // host-only write
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33);
        expect_val("hw_mem_we", 8'h1);    check({7'b0, mem_we});
        expect_val("hw_mem_wdata", 8'h33); check(mem_wdata);
        expect_val("hw_ack_early", 8'h0); check({7'b0, host_ack});
        step(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h33);
        expect_val("hw_ack", 8'h1);        check({7'b0, host_ack});
        expect_val("hw_no_reissue", 8'h0); check({7'b0, mem_we});
        expect_val("hw_mem20", 8'h33);     check(mem[8'h20]);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("hw_ack_drop", 8'h0); check({7'b0, host_ack});
        // contention: CPU load 0x10 vs host read 0x07
        for (int c = 1; c <= 4; c++) begin
            step(1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00);
            expect_val("cont_cpu_stall", 8'h0);  check({7'b0, cpu_stall});
            expect_val("cont_cpu_rdata", 8'h5A); check(cpu_rdata);
        end
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00);
        expect_val("cont5_stall", 8'h1);   check({7'b0, cpu_stall});
        expect_val("cont5_addr", 8'h07);   check(mem_addr);
        expect_val("cont5_rdata0", 8'h0);  check(cpu_rdata);
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00);
        expect_val("cont6_ack", 8'h1);      check({7'b0, host_ack});
        expect_val("cont6_hrdata", 8'hC4);  check(host_rdata);
        expect_val("cont6_stall", 8'h0);    check({7'b0, cpu_stall});
        expect_val("cont6_cpu_rdata", 8'h5A); check(cpu_rdata);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("cont7_ack", 8'h0); check({7'b0, host_ack});
        for (int c = 0; c < 3; c++) step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("hrdata_held", 8'hC4); check(host_rdata);
        // host drops after 2 lost cycles, then must lose 4 more
        for (int c = 0; c < 2; c++) step(1, 0, 8'h10, 8'h00, 1, 1, 8'h40, 8'h99);
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 8'h10, 8'h00, 1, 1, 8'h40, 8'h99);
            expect_val("restart_no_stall", 8'h0); check({7'b0, cpu_stall});
        end
        step(1, 0, 8'h10, 8'h00, 1, 1, 8'h40, 8'h99);
        expect_val("restart_forced", 8'h1); check({7'b0, cpu_stall});
        expect_val("restart_we", 8'h1);     check({7'b0, mem_we});
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("write_ack", 8'h1);        check({7'b0, host_ack});
        expect_val("write_keeps_rdata", 8'hC4); check(host_rdata);
        expect_val("mem40", 8'h99);           check(mem[8'h40]);
        // reset mid HOST_ACK
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("pre_rst_ack", 8'h1); check({7'b0, host_ack});
        expect_val("pre_rst_hrdata", 8'h5A); check(host_rdata);
        reset = 1'b1;
        #1;
        expect_val("async_ack_drop", 8'h0); check({7'b0, host_ack});
        expect_val("async_rdata_clr", 8'h0); check(host_rdata);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        expect_val("post_rst_no_ack", 8'h0); check({7'b0, host_ack});
        expect_val("mem20_kept", 8'h33);    check(mem[8'h20]);
        for (int c = 0; c < 4; c++) begin
            step(1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00);
            expect_val("post_rst_no_stall", 8'h0); check({7'b0, cpu_stall});
        end
        step(1, 0, 8'h10, 8'h00, 1, 0, 8'h07, 8'h00);
        expect_val("post_rst_forced", 8'h1); check({7'b0, cpu_stall});
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
